// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by the FSM top and the next-PC calculator.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0020;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int          JUMP_HI_BITS     = 4;

endpackage

// File: rtl/fetch_sequencer_npc_calc.sv
// Combinational next-PC selection: jump beats taken branch,
// which beats sequential. All arithmetic wraps modulo 2^32.
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target26_i,
    input  logic        jump_i,
    input  logic        npc_sel_i,
    output logic [31:0] pc4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] br_off;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;

    assign pc4_o  = pc_i + PC_INC;
    assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign br_tgt = pc4_o + br_off;
    assign j_tgt  = {pc4_o[31 -: JUMP_HI_BITS], target26_i, 2'b00};

    // Priority mux over the three redirect sources.
    always_comb begin
        next_pc_o = pc4_o;
        if (jump_i) begin
            next_pc_o = j_tgt;
        end else if (npc_sel_i) begin
            next_pc_o = br_tgt;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute control FSM: owns the PC, handshakes with imem,
// and presents one instruction per execute phase to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        start_up_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] target26,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam logic [1:0] BOOT  = ST_BOOT;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] EXEC  = ST_EXEC;
    localparam logic [1:0] HALT  = ST_HALT;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc4;
    logic [31:0] next_pc;

    npc_calc u_npc (
        .pc_i       (pc_q),
        .imm16_i    (imm16),
        .target26_i (target26),
        .jump_i     (jump),
        .npc_sel_i  (npc_sel),
        .pc4_o      (pc4),
        .next_pc_o  (next_pc)
    );

    // Next-state logic; halt outranks stall, stall outranks redirects.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        count_d = count_q;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (halt) begin
                    state_d = HALT;
                    count_d = count_q + 32'd1;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    count_d = count_q + 32'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!start_up_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level
// model of PC, retire count and halt status.
module tb_fetch_sequencer;

    localparam logic [31:0] RPC  = 32'h0040_0020;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        start_up_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall, npc_sel, jump, halt;
    logic [15:0] imm16;
    logic [25:0] target26;

    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc_out, instr_count;

    logic        d2_req, d2_valid, d2_halted;
    logic [31:0] d2_addr, d2_instr, d2_pc, d2_count;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_halted;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .start_up_n(start_up_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out),
        .stall(stall), .npc_sel(npc_sel), .imm16(imm16),
        .jump(jump), .target26(target26), .halt(halt),
        .halted(halted), .instr_count(instr_count)
    );

    fetch_sequencer #(.RESET_PC(RPC2)) dut2 (
        .clk(clk), .start_up_n(start_up_n),
        .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(d2_instr), .instr_valid(d2_valid), .pc_out(d2_pc),
        .stall(stall), .npc_sel(npc_sel), .imm16(imm16),
        .jump(jump), .target26(target26), .halt(halt),
        .halted(d2_halted), .instr_count(d2_count)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_ctl();
        stall    = 1'b0;
        npc_sel  = 1'b0;
        jump     = 1'b0;
        halt     = 1'b0;
        imm16    = '0;
        target26 = '0;
    endtask

    task automatic model_reset();
        m_pc     = RPC;
        m_count  = '0;
        m_halted = 1'b0;
    endtask

    // One instruction: fetch with wait states, stalls, then retire.
    task automatic drive_instr(input int waits, input int stalls,
                               input bit j, input bit br, input bit h,
                               input logic [15:0] imm,
                               input logic [25:0] t,
                               input logic [31:0] data);
        int          n;
        logic [31:0] pc4;
        logic [31:0] off;
        n = 0;
        while (imem_req !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL fetch_start req=%b want 1", imem_req);
        end
        total++;
        if (imem_addr !== m_pc) begin
            bad++;
            $display("FAIL fetch_addr got=%h want=%h", imem_addr, m_pc);
        end
        for (int w = 0; w < waits; w++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
            total++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc
                || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold req=%b addr=%h v=%b want 1 %h 0",
                         imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        total++;
        if (instr_valid !== 1'b1 || instr !== data || pc_out !== m_pc) begin
            bad++;
            $display("FAIL exec_present v=%b instr=%h pc=%h want 1 %h %h",
                     instr_valid, instr, pc_out, data, m_pc);
        end
        for (int s = 0; s < stalls; s++) begin
            stall    = 1'b1;
            jump     = 1'($urandom);
            npc_sel  = 1'($urandom);
            imm16    = 16'($urandom);
            target26 = 26'($urandom);
            step();
            total++;
            if (instr_valid !== 1'b1 || instr !== data || pc_out !== m_pc
                || instr_count !== m_count || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold v=%b instr=%h pc=%h cnt=%0d want 1 %h %h %0d",
                         instr_valid, instr, pc_out, instr_count,
                         data, m_pc, m_count);
            end
        end
        stall    = h ? 1'($urandom) : 1'b0;
        jump     = j;
        npc_sel  = br;
        halt     = h;
        imm16    = imm;
        target26 = t;
        step();
        clear_ctl();
        m_count = m_count + 32'd1;
        pc4     = m_pc + 32'd4;
        off     = {{16{imm[15]}}, imm};
        if (h) begin
            m_halted = 1'b1;
        end else if (j) begin
            m_pc = (pc4 & 32'hF000_0000) | (32'(t) << 2);
        end else if (br) begin
            m_pc = pc4 + off * 32'd4;
        end else begin
            m_pc = pc4;
        end
        total++;
        if (instr_count !== m_count || halted !== m_halted
            || imem_req !== !m_halted || imem_addr !== m_pc) begin
            bad++;
            $display("FAIL retire cnt=%0d halted=%b req=%b addr=%h want %0d %b %b %h",
                     instr_count, halted, imem_req, imem_addr,
                     m_count, m_halted, !m_halted, m_pc);
        end
    endtask

    task automatic test_reset();
        start_up_n = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        clear_ctl();
        step();
        step();
        model_reset();
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || pc_out !== RPC) begin
            bad++;
            $display("FAIL reset_fetch req=%b addr=%h pc=%h want 0 %h",
                     imem_req, imem_addr, pc_out, RPC);
        end
        total++;
        if (instr_valid !== 1'b0 || halted !== 1'b0
            || instr_count !== 32'd0 || instr !== 32'd0) begin
            bad++;
            $display("FAIL reset_state v=%b h=%b cnt=%0d instr=%h want 0 0 0 0",
                     instr_valid, halted, instr_count, instr);
        end
        total++;
        if (d2_addr !== RPC2) begin
            bad++;
            $display("FAIL reset_pc_param got=%h want=%h", d2_addr, RPC2);
        end
    endtask

    task automatic test_sequential();
        start_up_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        end
        total++;
        if (instr_count !== 32'd3 || imem_addr !== 32'h0040_002C) begin
            bad++;
            $display("FAIL seq_three cnt=%0d addr=%h want 3 0040002c",
                     instr_count, imem_addr);
        end
    endtask

    task automatic test_branch();
        drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        drive_instr(0, 0, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0, $urandom);
        total++;
        if (imem_addr !== 32'h0040_002C) begin
            bad++;
            $display("FAIL branch_back got=%h want=0040002c", imem_addr);
        end
        drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        drive_instr(0, 0, 1'b0, 1'b1, 1'b0, 16'h0003, 26'h0, $urandom);
        total++;
        if (imem_addr !== 32'h0040_0040) begin
            bad++;
            $display("FAIL branch_fwd got=%h want=00400040", imem_addr);
        end
    endtask

    task automatic test_jump();
        drive_instr(0, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h010000D, $urandom);
        total++;
        if (imem_addr !== 32'h0040_0034) begin
            bad++;
            $display("FAIL jump_plain got=%h want=00400034", imem_addr);
        end
        drive_instr(0, 0, 1'b1, 1'b1, 1'b0, 16'h0007, 26'h0100008, $urandom);
        total++;
        if (imem_addr !== 32'h0040_0020) begin
            bad++;
            $display("FAIL jump_wins got=%h want=00400020", imem_addr);
        end
    endtask

    task automatic test_wait_stall();
        drive_instr(3, 2, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h8C01_0004);
        total++;
        if (imem_addr !== 32'h0040_0024) begin
            bad++;
            $display("FAIL wait_stall_next got=%h want=00400024", imem_addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive_instr($urandom_range(0, 3), $urandom_range(0, 2),
                        1'($urandom), 1'($urandom), 1'b0,
                        16'($urandom), 26'($urandom), $urandom);
        end
    endtask

    task automatic test_halt();
        drive_instr(1, 1, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0, $urandom);
        for (int i = 0; i < 20; i++) begin
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            total++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold req=%b halted=%b v=%b want 0 1 0",
                         imem_req, halted, instr_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        imem_ack   = 1'b0;
        start_up_n = 1'b0;
        step();
        step();
        start_up_n = 1'b1;
        model_reset();
        drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        imem_ack   = 1'b1;
        start_up_n = 1'b0;
        step();
        total++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || instr_count !== 32'd0
            || halted !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_fetch req=%b addr=%h cnt=%0d h=%b want 0 %h 0 0",
                     imem_req, imem_addr, instr_count, halted, RPC);
        end
        step();
        imem_ack   = 1'b0;
        start_up_n = 1'b1;
        model_reset();
        drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        step();
        imem_ack   = 1'b0;
        start_up_n = 1'b0;
        step();
        total++;
        if (instr_count !== 32'd0 || instr_valid !== 1'b0 || imem_addr !== RPC) begin
            bad++;
            $display("FAIL reset_in_exec cnt=%0d v=%b addr=%h want 0 0 %h",
                     instr_count, instr_valid, imem_addr, RPC);
        end
    endtask

    task automatic test_wrap();
        start_up_n = 1'b0;
        imem_ack   = 1'b0;
        clear_ctl();
        step();
        step();
        model_reset();
        start_up_n = 1'b1;
        drive_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, $urandom);
        total++;
        if (d2_addr !== 32'h0000_0000 || d2_req !== 1'b1
            || d2_count !== 32'd1) begin
            bad++;
            $display("FAIL pc_wrap addr=%h req=%b cnt=%0d want 00000000 1 1",
                     d2_addr, d2_req, d2_count);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_stall();
        test_random();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
